// File: rtl/lane_event_arbiter_pkg.sv
// Shared definitions for the lane event arbiter: default geometry, event polarity
// and output register states.
package lane_event_arbiter_pkg;

  localparam int unsigned DEF_NUM_LANES  = 4;
  localparam int unsigned DEF_LANE_W     = 2;
  localparam int unsigned DEF_TS_W       = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 2;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  typedef enum logic {
    OUT_EMPTY,
    OUT_HOLD
  } out_state_e;

endpackage

// File: rtl/lane_event_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting lane found
// after last_grant, wrapping around.
module rr_arbiter
  import lane_event_arbiter_pkg::*;
#(
  parameter int unsigned NUM_LANES = DEF_NUM_LANES,
  parameter int unsigned LANE_W    = DEF_LANE_W
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [LANE_W-1:0]    last_grant,
  output logic [NUM_LANES-1:0] grant,
  output logic [LANE_W-1:0]    grant_idx,
  output logic                 grant_vld
);

  int unsigned cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_LANES; k++) begin
      cand = (32'(last_grant) + k) % NUM_LANES;
      if (!grant_vld && req[cand[LANE_W-1:0]]) begin
        grant_vld                    = 1'b1;
        grant_idx                    = cand[LANE_W-1:0];
        grant[cand[LANE_W-1:0]]      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lane_event_arbiter.sv
// Turns per-lane click level changes into timestamped events, buffers them per
// lane and merges all lanes round-robin onto one valid/ready stream.
module lane_event_arbiter
  import lane_event_arbiter_pkg::*;
#(
  parameter int unsigned NUM_LANES  = DEF_NUM_LANES,
  parameter int unsigned LANE_W     = DEF_LANE_W,
  parameter int unsigned TS_W       = DEF_TS_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] click_lvl,
  input  logic                 tick,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [LANE_W-1:0]    evt_lane,
  output logic                 evt_press,
  output logic [TS_W-1:0]      evt_ts,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENT_W = TS_W + 1;

  logic [NUM_LANES-1:0] prev_lvl;
  logic [NUM_LANES-1:0] rise;
  logic [NUM_LANES-1:0] fall;
  logic [TS_W-1:0]      ts;

  logic [NUM_LANES-1:0] fifo_empty;
  logic [NUM_LANES-1:0] fifo_full;
  logic [NUM_LANES-1:0] pop;
  logic [NUM_LANES-1:0] drop;
  logic [ENT_W-1:0]     fifo_head [NUM_LANES];

  logic [NUM_LANES-1:0] grant;
  logic [LANE_W-1:0]    grant_idx;
  logic                 grant_vld;
  logic [LANE_W-1:0]    last_grant;

  out_state_e state_q, state_d;
  logic       load;

  assign rise = click_lvl & ~prev_lvl;
  assign fall = ~click_lvl & prev_lvl;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_lvl <= '0;
      ts       <= '0;
    end else begin
      prev_lvl <= click_lvl;
      if (tick) ts <= ts + TS_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             chg;
    logic             push;

    assign chg           = rise[g] | fall[g];
    assign fifo_empty[g] = (cnt == '0);
    assign fifo_full[g]  = (cnt == CNT_W'(FIFO_DEPTH));
    // A full lane still takes the new edge when the arbiter pops it this cycle.
    assign push          = chg & (~fifo_full[g] | pop[g]);
    assign drop[g]       = chg & fifo_full[g] & ~pop[g];
    assign fifo_head[g]  = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {(rise[g] ? EVT_PRESS : EVT_RELEASE), ts};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop[g]) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop[g])      cnt <= cnt + CNT_W'(1);
        else if (!push && pop[g]) cnt <= cnt - CNT_W'(1);
      end
    end
  end

  rr_arbiter #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W)
  ) u_rr (
    .req        (~fifo_empty),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_vld  (grant_vld)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      OUT_EMPTY: begin
        load = 1'b1;
        if (grant_vld) state_d = OUT_HOLD;
      end
      OUT_HOLD: begin
        if (evt_ready) begin
          load    = 1'b1;
          state_d = grant_vld ? OUT_HOLD : OUT_EMPTY;
        end
      end
    endcase
  end

  assign pop       = (load && grant_vld) ? grant : '0;
  assign evt_valid = (state_q == OUT_HOLD);

  always_ff @(posedge clk) begin
    if (rst) state_q <= OUT_EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_lane   <= '0;
      evt_press  <= 1'b0;
      evt_ts     <= '0;
      last_grant <= LANE_W'(NUM_LANES - 1);
    end else if (load && grant_vld) begin
      evt_lane              <= grant_idx;
      {evt_press, evt_ts}   <= fifo_head[grant_idx];
      last_grant            <= grant_idx;
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst)              overrun <= 1'b0;
    else if (|drop)       overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end

endmodule
